// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------
// muldiv_pkg: shared opcodes, FSM states and helpers for muldiv_unit
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    return {{(XLEN-32){x[31]}}, x[31:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_core.sv
// ---------------------------------------------------------------
// muldiv_core: unsigned one-bit-per-cycle shift-add / restoring divide
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module muldiv_core #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_go,
  input  logic             i_is_div,
  input  logic [CNT_W-1:0] i_n_iter,
  input  logic [XLEN-1:0]  i_a,
  input  logic [XLEN-1:0]  i_b,
  output logic [XLEN-1:0]  o_lo,
  output logic [XLEN-1:0]  o_hi,
  output logic             o_finished
);

  localparam logic [CNT_W-1:0] c_xlen = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  logic [XLEN-1:0]  r_lo, r_hi, r_b;
  logic [CNT_W-1:0] r_cnt, r_n;
  logic             r_run, r_is_div;

  logic [XLEN:0] w_sum, w_rem_sh, w_diff;
  logic          w_ge;

  assign w_sum    = {1'b0, r_hi} + {1'b0, r_b};
  assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_b};
  assign w_ge     = (w_rem_sh >= {1'b0, r_b});

  // High during the final iteration, so the caller can leave CALC on that edge
  assign o_finished = r_run && (r_cnt == r_n - c_one);
  assign o_lo = r_lo;
  assign o_hi = r_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo     <= '0;
      r_hi     <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_n      <= '0;
      r_run    <= 1'b0;
      r_is_div <= 1'b0;
    end else if (i_go) begin
      // A short divide is pre-aligned so its dividend bits leave the top first
      r_lo     <= i_is_div ? (i_a << (c_xlen - i_n_iter)) : i_a;
      r_hi     <= '0;
      r_b      <= i_b;
      r_cnt    <= '0;
      r_n      <= i_n_iter;
      r_run    <= 1'b1;
      r_is_div <= i_is_div;
    end else if (r_run) begin
      r_cnt <= r_cnt + c_one;
      if (o_finished) r_run <= 1'b0;
      if (r_is_div) begin
        r_hi <= w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_ge};
      end else begin
        {r_hi, r_lo} <= r_lo[0] ? {w_sum, r_lo[XLEN-1:1]}
                                : {1'b0, r_hi, r_lo[XLEN-1:1]};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------
// muldiv_unit: iterative RV64M multiply/divide unit with EX-style write-back
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] rs1_rdata_i,
  input  logic [XLEN-1:0] rs2_rdata_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic [4:0]      reg_waddr_o,
  output logic [XLEN-1:0] reg_wdata_o,
  output logic            reg_wen_o
);

  localparam logic [XLEN-1:0] c_min64 = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] c_min32 = {{(XLEN-31){1'b1}}, 31'b0};

  state_t          r_state;
  logic [2:0]      r_op;
  logic            r_word, r_neg, r_special, r_wen;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_spec_val;

  logic [2:0]       w_op;
  logic             w_sa, w_sb, w_a_neg, w_b_neg, w_is_div, w_div0, w_ovf, w_special;
  logic             w_accept, w_go, w_fin, w_wen;
  logic [XLEN-1:0]  w_ea, w_eb, w_ma, w_mb, w_spec_val;
  logic [CNT_W-1:0] w_n;
  logic [XLEN-1:0]  w_lo, w_hi, w_plo, w_raw, w_negv, w_res, w_full;

  // Illegal W-forms of the high multiplies collapse to MULW
  assign w_op = (word_i && (op_i inside {OP_MULH, OP_MULHSU, OP_MULHU})) ? OP_MUL : op_i;
  assign w_is_div = w_op[2];
  assign w_sa = (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_sb = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);

  assign w_ea = word_i ? (w_sa ? sext32(rs1_rdata_i) : {{(XLEN-32){1'b0}}, rs1_rdata_i[31:0]})
                       : rs1_rdata_i;
  assign w_eb = word_i ? (w_sb ? sext32(rs2_rdata_i) : {{(XLEN-32){1'b0}}, rs2_rdata_i[31:0]})
                       : rs2_rdata_i;
  assign w_a_neg = w_sa & w_ea[XLEN-1];
  assign w_b_neg = w_sb & w_eb[XLEN-1];
  assign w_ma = w_a_neg ? -w_ea : w_ea;
  assign w_mb = w_b_neg ? -w_eb : w_eb;
  assign w_n  = word_i ? CNT_W'(32) : CNT_W'(XLEN);

  assign w_div0 = w_is_div && (w_eb == '0);
  assign w_ovf  = w_is_div && !w_op[0] && (w_eb == '1) &&
                  (w_ea == (word_i ? c_min32 : c_min64));
  assign w_special = w_div0 | w_ovf;
  assign w_spec_val = w_div0 ? (w_op[1] ? (word_i ? sext32(rs1_rdata_i) : rs1_rdata_i) : '1)
                             : (w_op[1] ? '0 : w_ea);

  assign w_accept = (r_state == IDLE) && start_i && !flush_i;
  assign w_go     = w_accept && !w_special;

  muldiv_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_go       (w_go),
    .i_is_div   (w_is_div),
    .i_n_iter   (w_n),
    .i_a        (w_ma),
    .i_b        (w_mb),
    .o_lo       (w_lo),
    .o_hi       (w_hi),
    .o_finished (w_fin)
  );

  // A 32-iteration multiply leaves its product shifted up by 32 in {hi,lo}
  assign w_plo = r_word ? {w_hi[31:0], w_lo[XLEN-1:32]} : w_lo;
  assign w_raw = r_op[2] ? (r_op[1] ? w_hi : w_lo) : ((r_op == OP_MUL) ? w_plo : w_hi);
  assign w_negv = (!r_op[2] && r_op != OP_MUL) ? (~w_hi + XLEN'(w_lo == '0)) : -w_raw;
  assign w_res  = r_special ? r_spec_val : (r_neg ? w_negv : w_raw);
  assign w_full = r_word ? sext32(w_res) : w_res;

  assign w_wen       = r_wen && !flush_i;
  assign reg_wen_o   = w_wen;
  assign reg_waddr_o = w_wen ? r_rd : 5'd0;
  assign reg_wdata_o = w_wen ? w_full : '0;
  assign ready_o     = (r_state == IDLE);
  assign busy_o      = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= OP_MUL;
      r_word     <= 1'b0;
      r_rd       <= 5'd0;
      r_neg      <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= '0;
      r_wen      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wen <= 1'b0;
          if (w_accept) begin
            r_op       <= w_op;
            r_word     <= word_i;
            r_rd       <= rd_i;
            r_neg      <= (w_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_special  <= w_special;
            r_spec_val <= w_spec_val;
            if (w_special) begin
              r_state <= DONE;
              r_wen   <= (rd_i != 5'd0);
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            r_state <= IDLE;
          end else if (w_fin) begin
            r_state <= DONE;
            r_wen   <= (r_rd != 5'd0);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_wen   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_wen   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------
// tb_muldiv_unit: scoreboard bench for muldiv_unit with arithmetic reference model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, word_i, flush_i;
  logic [2:0]  op_i;
  logic [63:0] rs1_rdata_i, rs2_rdata_i;
  logic [4:0]  rd_i;
  logic        ready_o, busy_o, reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [63:0] reg_wdata_o;

  muldiv_unit #(.XLEN(64), .CNT_W(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .word_i      (word_i),
    .rs1_rdata_i (rs1_rdata_i),
    .rs2_rdata_i (rs2_rdata_i),
    .rd_i        (rd_i),
    .flush_i     (flush_i),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_wen_o   (reg_wen_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    int          mode;  // 0 normal, 1 flush, 2 reset, 3 stray start, 4 start+flush in idle
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: RV64M semantics from plain signed/unsigned arithmetic
  function automatic logic [63:0] ref_result(input logic [2:0] op_in, input logic word,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [2:0]          op;
    logic signed [63:0]  sa, sb;
    logic signed [31:0]  sa32, sb32;
    logic [31:0]         ua32, ub32, r32;
    logic signed [127:0] p;
    logic [127:0]        up;
    op = (word && op_in inside {3'd1, 3'd2, 3'd3}) ? 3'd0 : op_in;
    sa = a; sb = b;
    ua32 = a[31:0]; ub32 = b[31:0];
    sa32 = a[31:0]; sb32 = b[31:0];
    if (word) begin
      r32 = '0;
      case (op)
        3'd0: r32 = ua32 * ub32;
        3'd4: if (ub32 == 0) r32 = '1;
              else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = ua32;
              else r32 = sa32 / sb32;
        3'd5: if (ub32 == 0) r32 = '1; else r32 = ua32 / ub32;
        3'd6: if (ub32 == 0) r32 = ua32;
              else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = '0;
              else r32 = sa32 % sb32;
        3'd7: if (ub32 == 0) r32 = ua32; else r32 = ua32 % ub32;
        default: r32 = '0;
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (op)
      3'd0: return a * b;
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * $signed({1'b0, b}); return p[127:64]; end
      3'd3: begin up = a * b; return up[127:64]; end
      3'd4: if (b == 0) return '1;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
            else return sa / sb;
      3'd5: if (b == 0) return '1; else return a / b;
      3'd6: if (b == 0) return a;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) return '0;
            else return sa % sb;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic word,
                                     input logic [63:0] a, input logic [63:0] b);
    logic ovf, dz;
    if (!op[2]) return word ? 32 : 64;
    dz  = word ? (b[31:0] == 0) : (b == 0);
    ovf = !op[0] && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                          : (a == 64'h8000_0000_0000_0000 && b == '1));
    return (dz || ovf) ? 0 : (word ? 32 : 64);
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return {32'd0, $urandom()};
      5: return 64'($urandom_range(0, 40)) - 64'd20;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Monitor: every write-back must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && reg_wen_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wen actual waddr=%0d data=%h expected no write", reg_waddr_o, reg_wdata_o);
      end else begin
        mon_e = sb_q.pop_front();
        check("wb_addr", 64'(reg_waddr_o), 64'(mon_e.rd));
        check("wb_data", reg_wdata_o, mon_e.data);
        check("wb_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic idle_inputs();
    start_i = 1'b0; flush_i = 1'b0; op_i = 3'd0; word_i = 1'b0;
    rs1_rdata_i = '0; rs2_rdata_i = '0; rd_i = 5'd0;
  endtask

  task automatic run_op(input vec_t v);
    int k, e_cyc, n;
    exp_t e;
    k = 0;
    while (!ready_o && k < 300) begin @(posedge clk); #1; k++; end
    check("wait_ready", 64'(ready_o), 64'd1);
    op_i = v.op; word_i = v.word; rs1_rdata_i = v.a; rs2_rdata_i = v.b; rd_i = v.rd;
    start_i = 1'b1;
    if (v.mode == 4) begin
      flush_i = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      check("start_flush_rejected", {62'd0, ready_o, busy_o}, 64'b10);
      return;
    end
    @(posedge clk); #1;
    e_cyc = cyc;
    idle_inputs();
    n = ref_latency(v.op, v.word, v.a, v.b);
    check("busy_after_accept", {62'd0, ready_o, busy_o}, 64'b01);
    if ((v.mode == 0 || v.mode == 3) && v.rd != 0) begin
      e.rd = v.rd; e.data = ref_result(v.op, v.word, v.a, v.b); e.cyc = e_cyc + n;
      sb_q.push_back(e);
    end
    if (v.mode == 1) begin
      repeat (9) @(posedge clk);
      #1 flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      check("flush_ready", 64'(ready_o), 64'd1);
      return;
    end
    if (v.mode == 2) begin
      repeat (19) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midop_reset_state", {ready_o, busy_o, reg_wen_o, reg_wdata_o},
            {1'b1, 1'b0, 1'b0, 64'd0});
      return;
    end
    if (v.mode == 3) begin
      repeat (5) @(posedge clk);
      #1;
      op_i = 3'd4; rs1_rdata_i = 64'd9; rs2_rdata_i = 64'd0; rd_i = 5'd31; start_i = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      check("busy_during_stray", 64'(busy_o), 64'd1);
    end
    k = 0;
    while (!ready_o && k < 300) begin @(posedge clk); #1; k++; end
    check("ready_latency", 64'(cyc - e_cyc), 64'(n + 1));
  endtask

  vec_t dir[$];
  vec_t rv;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {ready_o, busy_o, reg_wen_o, reg_waddr_o, reg_wdata_o},
          {1'b1, 1'b0, 1'b0, 5'd0, 64'd0});
    rst = 1'b0;

    dir.push_back('{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 0});
    dir.push_back('{3'd3, 1'b0, '1, '1, 5'd6, 0});
    dir.push_back('{3'd1, 1'b0, '1, '1, 5'd7, 0});
    dir.push_back('{3'd2, 1'b0, '1, 64'd2, 5'd8, 0});
    dir.push_back('{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd9, 0});
    dir.push_back('{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd10, 0});
    dir.push_back('{3'd5, 1'b1, 64'h1_0000_0010, 64'd4, 5'd11, 0});
    dir.push_back('{3'd4, 1'b0, 64'd9, 64'd0, 5'd12, 0});
    dir.push_back('{3'd7, 1'b0, 64'd9, 64'd0, 5'd13, 0});
    dir.push_back('{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd14, 0});
    dir.push_back('{3'd4, 1'b1, 64'h8000_0000, '1, 5'd15, 0});
    dir.push_back('{3'd6, 1'b1, 64'h8000_0000, '1, 5'd16, 0});
    dir.push_back('{3'd2, 1'b1, 64'd5, 64'd6, 5'd17, 0});
    dir.push_back('{3'd4, 1'b0, 64'd100, 64'd7, 5'd18, 1});
    dir.push_back('{3'd0, 1'b0, 64'd11, 64'd13, 5'd19, 3});
    dir.push_back('{3'd0, 1'b0, 64'd11, 64'd13, 5'd0, 0});
    dir.push_back('{3'd0, 1'b0, 64'd2, 64'd2, 5'd3, 4});
    dir.push_back('{3'd4, 1'b0, 64'd1000, 64'd7, 5'd21, 2});
    dir.push_back('{3'd0, 1'b0, 64'd3, 64'd4, 5'd20, 0});
    foreach (dir[i]) run_op(dir[i]);

    for (int i = 0; i < 40; i++) begin
      rv.op = 3'($urandom_range(0, 7));
      rv.word = 1'($urandom_range(0, 1));
      rv.a = pick();
      rv.b = pick();
      rv.rd = 5'($urandom_range(0, 31));
      rv.mode = 0;
      run_op(rv);
    end

    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit beside the EX stage.
- Consumes rs1/rs2 operand values read from the register file.
- Produces one register write-back (waddr/wdata/wen) per accepted operation, in the same format as EX.
- Multi-cycle; EX stalls on busy_o and the unit owns the write port on its completion cycle.

Parameters:
XLEN, 64, operand/result width
CNT_W, 7, iteration counter width (holds 0..XLEN)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start_i  in  1  request; accepted only when ready_o=1
op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
word_i  in  1  1 = W-variant (MULW/DIVW/DIVUW/REMW/REMUW); op_i 1..3 with word_i=1 is illegal
rs1_rdata_i  in  64  operand a
rs2_rdata_i  in  64  operand b
rd_i  in  5  destination register
flush_i  in  1  abort current operation
ready_o  out  1  IDLE; a new op can be accepted
busy_o  out  1  operation in flight (not IDLE)
reg_waddr_o  out  5  write-back address
reg_wdata_o  out  64  write-back data
reg_wen_o  out  1  write-back strobe, one-cycle pulse

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, counter=0; all datapath registers cleared.
  - Outputs: ready_o=1, busy_o=0, reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0.
  - Reset mid-operation abandons the op with no write.
- States:
  - IDLE -> CALC on start_i & ~flush_i.
  - IDLE -> DONE directly for special-case divides.
  - CALC -> DONE when counter reaches N.
  - DONE -> IDLE unconditionally.
- Acceptance (cycle t):
  - Latch op, word, rd.
  - Operands: W-variants use the low 32 bits, sign- or zero-extended per signedness.
  - Signed ops store magnitudes plus result-sign flags.
- CALC: one bit per cycle. N=64, or 32 for W-variants.
  - Multiply: shift-add into a 128-bit accumulator.
  - Divide: restoring shift-subtract; quotient/remainder in registers.
- Timing:
  - reg_wen_o=1 in cycle t+N+1 (DONE), 0 otherwise; wdata/waddr valid only with wen.
  - ready_o returns in cycle t+N+2; back-to-back start is accepted that cycle.
- Result selection (negate at DONE where a sign flag is set):
  - MUL: low 64.
  - MULH/MULHSU/MULHU: high 64 of the signed×signed / signed×unsigned / unsigned×unsigned product.
  - DIV/DIVU: quotient. REM/REMU: remainder (sign follows dividend).
  - W-variants: low 32 bits of the result, sign-extended to 64 (including DIVUW/REMUW).
- Special cases (decided at acceptance; go IDLE->DONE, reg_wen_o at t+1):
  - Divide by zero: quotient = all ones; remainder = dividend (W: low 32 of rs1, sign-extended).
  - Signed overflow (most-negative / -1, 64- or 32-bit per word_i): quotient = most-negative; remainder = 0.
- rd_i=0: op completes normally with full latency, but reg_wen_o stays 0.
- start_i while busy: ignored; no queueing, no state change.
- flush_i:
  - Any cycle in CALC or DONE: next state IDLE, reg_wen_o forced 0 that cycle.
  - flush_i and start_i together in IDLE: start rejected.
- Illegal op (op_i 1..3 with word_i=1): treated as MULW (op 0, word 1).

Decomposition:
- Shared package muldiv_pkg: op encodings (OP_MUL..OP_REMU), state enum (IDLE/CALC/DONE), XLEN.
- Sub-module muldiv_core: unsigned 64-bit iterative engine.
  - Inputs: a, b, is_div, n_iter, go.
  - Outputs: lo, hi, finished.
- Top module handles sign handling, special cases, FSM, and write-back.

Test Plan:
- MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD), rd=5, start at t -> reg_wen_o=1 only at t+65, waddr=5, wdata=0xFFFF_FFFF_FFFF_FFEB; ready_o=1 at t+66.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> wdata=0xFFFF_FFFF_FFFF_FFFE; MULH same operands -> 0; MULHSU a=-1, b=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV a=-20, b=3 -> 0xFFFF_FFFF_FFFF_FFFA (-6); REM same operands -> 0xFFFF_FFFF_FFFF_FFFE (-2); DIVUW a=0x1_0000_0010, b=4 -> 4 at t+33.
- DIV b=0, a=9 -> all ones at t+1; REMU b=0 -> 9; DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000; DIVW a=0x8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000; REMW same operands -> 0.
- Start DIV, assert flush_i at t+10 -> no reg_wen_o ever, ready_o=1 at t+11; start ignored during busy; rd=0 op -> no wen.
- rst=1 pulse at t+20 mid-CALC -> next cycle ready_o=1, busy_o=0, reg_wen_o=0, wdata=0; fresh MUL 3×4 afterwards returns 12.
